// File: rtl/hilo_mul_unit.sv
// Iterative multiply / multiply-accumulate unit with HI/LO register pair.
// Optional feature: define MUL_FLUSH_EN to add the flush port for aborting in-flight operations.
module hilo_mul_unit #(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MUL_FLUSH_EN
    input  logic             flush,
`endif
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = WIDTH / ITER_BITS;
    localparam int CNT_W = $clog2(STEPS) + 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_r;
    logic [PW-1:0]      mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [PW-1:0]      prod_r;
    logic               sign_r;
    logic [2:0]         op_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;
    logic               busy_r;

    logic               flush_s;
    logic [ITER_BITS-1:0] digit_s;
    logic [PW-1:0]      pp_s;
    logic [PW-1:0]      prod_next_s;
    logic [PW-1:0]      p_s;
    logic [PW-1:0]      acc_s;

    // Magnitude fits in WIDTH unsigned bits, so the most negative value stays exact.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

`ifdef MUL_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = busy_r | (start & (state_r == IDLE) & ~op[2]);

    // Partial product for this step, signed fix-up and HI:LO accumulate value.
    always_comb begin
        digit_s = mplier_r[ITER_BITS-1:0];
        pp_s    = '0;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (digit_s[i]) begin
                pp_s = pp_s + (mcand_r << i);
            end else begin
                pp_s = pp_s;
            end
        end
        prod_next_s = prod_r + pp_s;
        p_s         = sign_r ? ('0 - prod_r) : prod_r;
        case (op_r)
            3'b010:  acc_s = {hi_r, lo_r} + p_s;
            3'b011:  acc_s = {hi_r, lo_r} - p_s;
            default: acc_s = p_s;
        endcase
    end

    // Control FSM, shift-add datapath and HI/LO registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= IDLE;
            mcand_r  <= '0;
            mplier_r <= '0;
            prod_r   <= '0;
            sign_r   <= 1'b0;
            op_r     <= 3'b000;
            cnt_r    <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (flush_s) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                3'b000, 3'b001, 3'b010, 3'b011: begin
                                    mcand_r  <= {{WIDTH{1'b0}}, (op == 3'b001) ? a : mag(a)};
                                    mplier_r <= (op == 3'b001) ? b : mag(b);
                                    sign_r   <= (op != 3'b001) & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    op_r     <= op;
                                    cnt_r    <= '0;
                                    prod_r   <= '0;
                                    state_r  <= RUN;
                                    busy_r   <= 1'b1;
                                end
                                3'b100: begin
                                    hi_r   <= a;
                                    done_r <= 1'b1;
                                end
                                3'b101: begin
                                    lo_r   <= a;
                                    done_r <= 1'b1;
                                end
                                default: begin
                                    state_r <= IDLE;
                                end
                            endcase
                        end
                    end
                    RUN: begin
                        prod_r   <= prod_next_s;
                        mcand_r  <= mcand_r << ITER_BITS;
                        mplier_r <= mplier_r >> ITER_BITS;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        if (cnt_r == CNT_W'(STEPS - 1)) begin
                            state_r <= FINISH;
                        end
                    end
                    FINISH: begin
                        {hi_r, lo_r} <= acc_s;
                        done_r       <= 1'b1;
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed, table-driven bench for hilo_mul_unit with hand-written abort sequences.
module tb_hilo_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    hilo_mul_unit #(.WIDTH(32), .ITER_BITS(1)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
`ifdef MUL_FLUSH_EN
        .flush (flush),
`endif
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          stalls;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, then wait (bounded) for done; lat = edges from accept to done, -1 if none.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output int stalls, output logic req_stall);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        #1 req_stall = stall;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        stalls = 0;
        for (int c = 1; c <= 40; c++) begin
            if (stall) stalls++;
            if (done) begin
                lat = c - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    int   lat;
    int   stl;
    logic rq;
    int   ndone;
    logic [31:0] hold_lo;

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0; flush = 1'b0;
        vecs[0] = '{3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33};
        vecs[1] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
        vecs[2] = '{3'b100, 32'h00000000, 32'd0,        32'h00000000, 32'h00000001, 0, 0};
        vecs[3] = '{3'b101, 32'd10,       32'd0,        32'h00000000, 32'd10,       0, 0};
        vecs[4] = '{3'b010, 32'd4,        32'd5,        32'h00000000, 32'd30,       33, 33};
        vecs[5] = '{3'b011, 32'd40,       32'd1,        32'hFFFFFFFF, 32'hFFFFFFF6, 33, 33};
        vecs[6] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33};
        vecs[7] = '{3'b000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 33, 33};
        vecs[8] = '{3'b010, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'h7FFFFFFB, 33, 33};
        vecs[9] = '{3'b110, 32'h12345678, 32'd9,        32'hFFFFFFFF, 32'h7FFFFFFB, -1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stl, rq);
            check($sformatf("v%0d_req_stall", i), {63'd0, rq}, {63'd0, ~vecs[i].op[2]});
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_stall_cycles", i), 64'(stl), 64'(vecs[i].stalls));
            check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
            check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // start pulse during RUN is ignored; HI/LO hold until FINISH
        hold_lo = lo;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("run_hold_lo", {32'd0, lo}, {32'd0, hold_lo});
        check("run_busy", {63'd0, busy}, 64'd1);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignored_start_done_count", 64'(ndone), 64'd1);
        check("ignored_start_result", {hi, lo}, 64'd6);

        // reset in RUN cycle 10 aborts without a HI/LO write
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        run_op(3'b000, 32'd2, 32'd3, lat, stl, rq);
        check("post_rst_latency", 64'(lat), 64'd33);
        check("post_rst_result", {hi, lo}, 64'd6);

`ifdef MUL_FLUSH_EN
        // flush in RUN cycle 5 abandons the product
        run_op(3'b101, 32'd9, 32'd0, lat, stl, rq);
        check("flush_mtlo", {32'd0, lo}, 64'd9);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush_done_count", 64'(ndone), 64'd0);
        check("flush_lo", {32'd0, lo}, 64'd9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
